// File: rtl/xor_descrambler_32.sv
// rtl/xor_descrambler_32.sv - receive-side 32-bit XOR descrambler with Galois LFSR keystream
//
// Purpose: recovers plaintext words (out = in ^ keystream). The keystream is a
// 32-bit Galois LFSR that steps once per accepted word, in lockstep with the
// transmit-side scrambler. There is valid/ready flow control on both sides and
// a single-word output stage.
//
// Optional feature macro: XOR_DESCR_PARITY_EN (adds in_parity / out_perr).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   seed_load  in   1      load seed into keystream; moves FSM to RUN
//   seed       in   32     keystream seed (0 is replaced by 1)
//   in_valid   in   1      scrambled word present
//   in_data    in   32     scrambled word
//   in_ready   out  1      block accepts in_data this cycle
//   out_valid  out  1      descrambled word present
//   out_data   out  32     descrambled word
//   out_ready  in   1      sink accepts out_data this cycle
//   word_cnt   out  CNT_W  accepted words since reset/seed, saturating
//   in_parity  in   1      (XOR_DESCR_PARITY_EN) even parity of in_data
//   out_perr   out  1      (XOR_DESCR_PARITY_EN) parity error, travels with out_data

module xor_descrambler_32 #(
    parameter int              WIDTH    = 32,
    parameter logic [31:0]     POLY     = 32'h00400007,
    parameter logic [31:0]     SEED_RST = 32'h00000001,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
`ifdef XOR_DESCR_PARITY_EN
    ,
    input  logic             in_parity,
    output logic             out_perr
`endif
);

    localparam logic [0:0] ST_UNSEEDED = 1'b0;
    localparam logic [0:0] ST_RUN      = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_ks;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_ks_next;
    logic [WIDTH-1:0] w_seed_eff;

    // The output slot is free when empty or being drained this cycle. A
    // seed_load cycle never accepts, so the keystream is never stepped and
    // reseeded in the same edge.
    assign w_in_ready = (r_state == ST_RUN) & ~seed_load & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;

    // Galois step: shift left, fold the tap mask back in when bit 31 falls out.
    assign w_ks_next  = {r_ks[WIDTH-2:0], 1'b0} ^ (r_ks[WIDTH-1] ? POLY : '0);

    // An all-zero LFSR would stay zero forever; substitute 1.
    assign w_seed_eff = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_UNSEEDED;
            r_ks        <= SEED_RST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_word_cnt  <= '0;
        end else begin
            if (seed_load) begin
                r_state    <= ST_RUN;
                r_ks       <= w_seed_eff;
                r_word_cnt <= '0;
            end

            if (w_accept) begin
                r_out_data  <= in_data ^ r_ks;
                r_out_valid <= 1'b1;
                r_ks        <= w_ks_next;
                if (r_word_cnt != {CNT_W{1'b1}}) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef XOR_DESCR_PARITY_EN
    logic r_out_perr;

    // Checked on the scrambled side: in_parity is even parity of in_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_perr <= 1'b0;
        end else if (w_accept) begin
            r_out_perr <= (^in_data) ^ in_parity;
        end
    end

    assign out_perr = r_out_perr;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_xor_descrambler_32.sv
// tb/tb_xor_descrambler_32.sv - randomized self-checking bench for xor_descrambler_32

module tb_xor_descrambler_32;

    localparam logic [31:0] POLY = 32'h00400007;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [15:0] word_cnt;
`ifdef XOR_DESCR_PARITY_EN
    logic        in_parity = 1'b0;
    logic        out_perr;
`endif

    always #5 clk = ~clk;

    xor_descrambler_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
`ifdef XOR_DESCR_PARITY_EN
        ,
        .in_parity (in_parity),
        .out_perr  (out_perr)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending output words as a queue ({perr, data}),
    // keystream as a value advanced by multiplication by x modulo the polynomial.
    bit          m_seeded;
    logic [31:0] m_ks;
    int          m_cnt;
    logic [32:0] m_q[$];
    logic [31:0] obs_q[$];

    function automatic logic [31:0] mul_x(input logic [31:0] k);
        logic [32:0] wide;
        wide = {k, 1'b0};
        if (wide[32]) wide = wide ^ {1'b1, POLY};
        return wide[31:0];
    endfunction

    // One clock cycle: drive on negedge, check current outputs, advance model.
    task automatic cyc(input logic sl, input logic [31:0] sd, input logic iv,
                       input logic [31:0] id, input logic ordy, input logic pflip);
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        seed_load = sl;
        seed      = sd;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
`ifdef XOR_DESCR_PARITY_EN
        in_parity = (^id) ^ pflip;
`endif
        #1;
        exp_rdy = m_seeded && !sl && (m_q.size() == 0 || ordy);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0][31:0]);
`ifdef XOR_DESCR_PARITY_EN
            chk("out_perr", {31'b0, out_perr}, {31'b0, m_q[0][32]});
`endif
            if (ordy) obs_q.push_back(out_data);
        end
        chk("word_cnt", {16'b0, word_cnt}, m_cnt);

        acc = iv && exp_rdy;
        if (ordy && m_q.size() != 0) void'(m_q.pop_front());
        if (acc) begin
            m_q.push_back({pflip, id ^ m_ks});
            m_ks  = mul_x(m_ks);
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
        if (sl) begin
            m_seeded = 1'b1;
            m_ks     = (sd == 0) ? 32'h1 : sd;
            m_cnt    = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        seed_load = 1'b0;
        m_seeded  = 1'b0;
        m_ks      = 32'h1;
        m_cnt     = 0;
        m_q.delete();
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        do_reset();

        // Reset state and no acceptance before seeding.
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 32'hDEAD0000 + i, 1'b1, 1'b0);
        chk("unseeded_no_out", {31'b0, out_valid}, 32'h0);

        // Seed 1, zeros in: keystream powers of x.
        obs_q.delete();
        cyc(1'b1, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t1_nobs", obs_q.size(), 3);
        chk("t1_w0", obs_q[0], 32'h1);
        chk("t1_w1", obs_q[1], 32'h2);
        chk("t1_w2", obs_q[2], 32'h4);
        chk("t1_cnt", {16'b0, word_cnt}, 32'd3);

        // Keystream wrap at bit 31.
        obs_q.delete();
        cyc(1'b1, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t2_w0", obs_q[0], 32'h7FFFFFFF);
        chk("t2_w1", obs_q[1], 32'hFFBFFFF8);

        // Backpressure: hold first word, block second, then accept+drain together.
        cyc(1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 32'h22222222, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h22222222, 1'b1, 1'b0);
        #2;
        chk("t3_valid_stays", {31'b0, out_valid}, 32'h1);
        idle(2, 1'b1);

        // Zero seed maps to 1; seed_load with in_valid blocks acceptance.
        obs_q.delete();
        cyc(1'b1, 32'h0, 1'b1, 32'h12345678, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t4_nobs", obs_q.size(), 1);
        chk("t4_zero_seed", obs_q[0], 32'h1);

        // Reset while a word is held.
        cyc(1'b0, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("t5_valid", {31'b0, out_valid}, 32'h0);
        chk("t5_cnt", {16'b0, word_cnt}, 32'h0);

        // Randomized traffic with occasional reseeds and parity flips.
        cyc(1'b1, $urandom, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0), $urandom, $urandom_range(0, 3) != 0,
                $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        idle(2, 1'b1);

        // Counter saturation.
        cyc(1'b1, $urandom, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) cyc(1'b0, 32'h0, 1'b1, $urandom, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t6_sat", {16'b0, word_cnt}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
